// File: rtl/seg7_pkg.sv
// Shared segment constants and small helpers for the seven-segment scanner.
// Patterns are active-low, bit order gfedcba.
package seg7_pkg;

    typedef logic [3:0] hex_t;
    typedef logic [6:0] seg_t;
    typedef logic [1:0] idx_t;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h03;
    localparam seg_t SEG_C = 7'h46;
    localparam seg_t SEG_D = 7'h21;
    localparam seg_t SEG_E = 7'h06;
    localparam seg_t SEG_F = 7'h0E;

    localparam seg_t       SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // One-hot-low anode enable for a scan slot.
    function automatic logic [3:0] an_sel(input idx_t i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex to active-low seven-segment decoder.
// Backed by the shared constant table.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode display driver.
// Anodes and cathodes are registered together from the same scan slot.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int COUNT_BITS = 17
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dig4,
    output logic [3:0] an,
    output logic [6:0] ca
);

    logic [COUNT_BITS-1:0] cnt;
    idx_t                  idx;
    hex_t                  cur;
    seg_t                  seg;

    assign idx = cnt[COUNT_BITS-1 -: 2];

    always_comb begin
        cur = dig1;
        unique case (idx)
            2'd0: cur = dig1;
            2'd1: cur = dig2;
            2'd2: cur = dig3;
            2'd3: cur = dig4;
        endcase
    end

    seg7_decoder u_dec (
        .hex (cur),
        .seg (seg)
    );

    // Outputs follow the pre-increment slot, giving the one-clock lag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
            an  <= AN_OFF;
            ca  <= SEG_OFF;
        end else begin
            cnt <= cnt + 1'b1;
            an  <= an_sel(idx);
            ca  <= seg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed scoreboard bench for seg7_scan_display, COUNT_BITS=4.
// Expected outputs come from a slot model and the decode table.
module tb_seg7_scan_display;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] ca;
    } exp_t;

    localparam logic [6:0] SEGS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] dig1 = 4'h0;
    logic [3:0] dig2 = 4'h0;
    logic [3:0] dig3 = 4'h0;
    logic [3:0] dig4 = 4'h0;
    logic [3:0] an;
    logic [6:0] ca;

    int   total = 0;
    int   bad   = 0;
    int   m     = 0;
    exp_t sb[$];

    seg7_scan_display #(.COUNT_BITS(4)) dut (
        .clk  (clk),
        .clr  (clr),
        .dig1 (dig1),
        .dig2 (dig2),
        .dig3 (dig3),
        .dig4 (dig4),
        .an   (an),
        .ca   (ca)
    );

    always #2 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input exp_t obs, input exp_t want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s got an=%b ca=%h want an=%b ca=%h",
                   tag, obs.an, obs.ca, want.an, want.ca);
        end
    endtask

    function automatic exp_t model(input int slot);
        exp_t e;
        logic [3:0] d;
        case (slot)
            0: d = dig1;
            1: d = dig2;
            2: d = dig3;
            default: d = dig4;
        endcase
        e.an = 4'hF;
        e.an[slot] = 1'b0;
        e.ca = SEGS[d];
        return e;
    endfunction

    task automatic reset_step(input string tag);
        exp_t e;
        sb.push_back(exp_t'({4'hF, 7'h7F}));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, exp_t'({an, ca}), e);
    endtask

    task automatic scan_step(input string tag);
        exp_t e;
        sb.push_back(model(m / 4));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, exp_t'({an, ca}), e);
        total++;
        assert ($countones(~an) == 1) else begin
            bad++;
            $error("FAIL onehot got an=%b want one low bit", an);
        end
        m = (m + 1) % 16;
    endtask

    initial begin
        exp_t prev;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) reset_step("reset_hold");

        dig1 = 4'h5;
        dig2 = 4'hA;
        dig3 = 4'h3;
        dig4 = 4'hA;
        clr  = 1'b1;
        m    = 0;
        for (int i = 0; i < 48; i++) scan_step("scan");

        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 16 && (m / 4) != 0; k++)
                scan_step("sweep_wait");
            dig1 = 4'(v);
            scan_step("decode");
        end

        for (int k = 0; k < 16 && m != 9; k++) scan_step("live_wait");
        prev = exp_t'({an, ca});
        chk("live_before", prev, exp_t'({4'b1011, 7'h30}));
        dig3 = 4'h8;
        scan_step("live_after");

        for (int k = 0; k < 3; k++) scan_step("pre_reset");
        clr = 1'b0;
        #1;
        chk("async_reset", exp_t'({an, ca}), exp_t'({4'hF, 7'h7F}));
        reset_step("reset_mid");

        clr = 1'b1;
        m   = 0;
        for (int i = 0; i < 20; i++) scan_step("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Time-multiplexed driver for a 4-digit common-anode seven-segment display, Basys3-style with active-low anodes and cathodes.
- Takes four 4-bit hex digit values from the rest of the design and scans them one digit at a time.
- Drives one anode enable plus the matching segment pattern, so all four digits appear lit to the eye.
- Sits at the top level, directly between the design's digit outputs and the board pins.

Parameters:
COUNT_BITS, 17, width of the free-running refresh counter. Each digit is held for 2^(COUNT_BITS-2) clocks; a full scan takes 2^COUNT_BITS clocks (1.31 ms at 100 MHz). Must be at least 3.

Ports:
clk  input  1  system clock, rising-edge active
clr  input  1  reset, asynchronous, active-low (clr=0 resets)
dig1  input  4  hex value shown on digit 0 (an[0], rightmost)
dig2  input  4  hex value shown on digit 1 (an[1])
dig3  input  4  hex value shown on digit 2 (an[2])
dig4  input  4  hex value shown on digit 3 (an[3], leftmost)
an  output  4  anode enables, active-low, one-hot-low while scanning
ca  output  7  segment cathodes, active-low; ca[0]=a, ca[1]=b, ..., ca[6]=g

Behaviour:
- One clock domain. Reset is asynchronous, active-low on clr.
- While clr=0: refresh counter = 0, an = 4'b1111 (all digits off), ca = 7'h7F (all segments off).
- Refresh counter cnt[COUNT_BITS-1:0] increments by 1 on every rising edge with clr=1. It wraps from all-ones to 0 with no pause.
- Scan index idx = cnt[COUNT_BITS-1:COUNT_BITS-2]. Scan order is 0,1,2,3,0,...
- an and ca are registered. At each rising edge (clr=1) they load from the current (pre-increment) idx:
  - an <= ~(4'b0001 << idx)
  - ca <= decode(digit selected by idx)
  - idx 0→dig1, 1→dig2, 2→dig3, 3→dig4
- Consequently:
  - First edge after reset release: an=4'b1110, ca=decode(dig1).
  - an switches to 4'b1101 on the edge after cnt reaches 2^(COUNT_BITS-2); this one-clock lag is required.
- an and ca always update on the same edge. An anode is never enabled with another digit's pattern.
- Digit inputs are sampled every clock, not latched per slot. A change on the active digit appears on ca at the next rising edge.
- Decode is full hex, segment order gfedcba, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- No blanking or decimal-point support; a value of 0 shows "0".
- Reset asserted mid-scan: outputs go to the off values immediately (asynchronously). On release, scanning restarts at idx 0.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-low segment constant table (SEG_0..SEG_F)
  - SEG_OFF = 7'h7F
  - AN_OFF = 4'hF
- One natural sub-module: seg7_decoder. Purely combinational, 4-bit hex in, 7-bit active-low segments out, backed by the package table.
- The top module keeps the counter, the 4:1 digit mux and the output registers.

Test Plan (COUNT_BITS=4, so 4 clocks per digit; clk period 4 ns):
- Reset: hold clr=0 with clock running → an=4'b1111, ca=7'h7F every cycle. Assert clr=0 mid-scan → outputs return to the off values before the next clock edge.
- Scan order: release clr with dig1=5, dig2=A, dig3=3, dig4=A. Expect each state held 4 clocks, wrapping to digit 0 after 16 clocks:
  - an=1110, ca=12
  - an=1101, ca=08
  - an=1011, ca=30
  - an=0111, ca=08
- First-edge latency: first rising edge after clr=1 gives an=1110, ca=decode(dig1). Transition to an=1101 occurs exactly 4 edges later.
- Decoder sweep: cycle dig1 through 0..F while digit 0 is active. ca must match 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E on the following edge.
- Live update: change dig3 from 3 to 8 while an=1011 → ca goes 30→00 on the next rising edge, and an is unchanged.
- One-hot check over 3 full scans: an always has exactly one 0 bit (after the first post-reset edge). an and ca never change on different edges.
